// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, carry held
// in a register between chunks, START/BUSY/DONE handshake.

module seq_adder_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module seq_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  seq_adder_ha u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  seq_adder_ha u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  assign co = c1 | c2;
endmodule

module seq_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             cm
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    seq_adder_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign co = c[CHUNK];
  // carry into the chunk MSB, used for signed overflow
  assign cm = c[CHUNK-1];
endmodule

module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic             CY,
  output logic             OVF
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] res_full;
  logic             cy_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] sum;
  logic             co;
  logic             cm;
  logic             last;

  seq_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_q[CHUNK-1:0]),
    .b   (b_q[CHUNK-1:0]),
    .ci  (cy_q),
    .sum (sum),
    .co  (co),
    .cm  (cm)
  );

  assign last = (cnt == CW'(N - 1));

  if (N == 1) begin : g_one
    assign a_nxt    = a_q;
    assign b_nxt    = b_q;
    assign res_full = sum;
  end else begin : g_multi
    // upper chunks collected so far, LS chunk lowest
    logic [WIDTH-CHUNK-1:0] res_q;

    assign a_nxt    = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
    assign b_nxt    = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
    assign res_full = {sum, res_q};

    always_ff @(posedge CLK) begin
      if (RST)
        res_q <= '0;
      else if (state == RUN)
        res_q <= res_full[WIDTH-1:CHUNK];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cy_q  <= 1'b0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      OUT   <= '0;
      CY    <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            a_q   <= A;
            b_q   <= SUB ? ~B : B;
            cy_q  <= CIN ^ SUB;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q  <= a_nxt;
          b_q  <= b_nxt;
          cy_q <= co;
          cnt  <= cnt + 1'b1;
          if (last) begin
            OUT   <= res_full;
            CY    <= co;
            OVF   <= cm ^ co;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: CHUNK=4, 16 and 1 instances
// against hand-computed results and handshake timing.

module tb_seq_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy [3];
  logic        done [3];
  logic [15:0] out  [3];
  logic        cy   [3];
  logic        ovf  [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(16), .CHUNK(4)) u_d4 (
    .CLK(clk), .RST(rst), .START(start[0]), .SUB(sub),
    .A(a), .B(b), .CIN(cin), .BUSY(busy[0]), .DONE(done[0]),
    .OUT(out[0]), .CY(cy[0]), .OVF(ovf[0])
  );

  seq_adder #(.WIDTH(16), .CHUNK(16)) u_d16 (
    .CLK(clk), .RST(rst), .START(start[1]), .SUB(sub),
    .A(a), .B(b), .CIN(cin), .BUSY(busy[1]), .DONE(done[1]),
    .OUT(out[1]), .CY(cy[1]), .OVF(ovf[1])
  );

  seq_adder #(.WIDTH(16), .CHUNK(1)) u_d1 (
    .CLK(clk), .RST(rst), .START(start[2]), .SUB(sub),
    .A(a), .B(b), .CIN(cin), .BUSY(busy[2]), .DONE(done[2]),
    .OUT(out[2]), .CY(cy[2]), .OVF(ovf[2])
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int d, input logic [15:0] va,
                       input logic [15:0] vb, input logic vsub,
                       input logic vcin, input logic [15:0] eo,
                       input logic ec, input logic ev, input int n,
                       input string tag);
    @(negedge clk);
    a = va; b = vb; sub = vsub; cin = vcin; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, 16'(busy[d]), 16'd1);
      chk({tag, "_nodone"}, 16'(done[d]), 16'd0);
      @(negedge clk);
    end
    chk({tag, "_busy_end"}, 16'(busy[d]), 16'd0);
    chk({tag, "_done"}, 16'(done[d]), 16'd1);
    chk({tag, "_out"}, out[d], eo);
    chk({tag, "_cy"}, 16'(cy[d]), 16'(ec));
    chk({tag, "_ovf"}, 16'(ovf[d]), 16'(ev));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 16'(done[d]), 16'd0);
    chk({tag, "_out_hold"}, out[d], eo);
  endtask

  initial begin
    rst = 1'b1; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 16'(busy[i]), 16'd0);
      chk("rst_done", 16'(done[i]), 16'd0);
      chk("rst_out", out[i], 16'h0000);
      chk("rst_cy", 16'(cy[i]), 16'd0);
      chk("rst_ovf", 16'(ovf[i]), 16'd0);
    end
    rst = 1'b0;

    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4, "add");
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "ripple");
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "ovf_add");
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 4, "sub_neg");
    do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4, "sub_ovf");
    do_op(0, 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 4, "sub_bin");

    // START held with new operands through RUN and FIN
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ign_busy", 16'(busy[0]), 16'd1);
      chk("ign_out_old", out[0], 16'h0001);
      @(negedge clk);
    end
    chk("ign_done", 16'(done[0]), 16'd1);
    chk("ign_out", out[0], 16'h3333);
    chk("ign_cy", 16'(cy[0]), 16'd0);
    chk("ign_ovf", 16'(ovf[0]), 16'd0);
    @(negedge clk);
    chk("ign_fin_busy", 16'(busy[0]), 16'd0);
    chk("ign_fin_done", 16'(done[0]), 16'd0);
    start[0] = 1'b0;
    @(negedge clk);
    chk("ign_idle_busy", 16'(busy[0]), 16'd0);
    chk("ign_idle_out", out[0], 16'h3333);

    // reset on the second RUN cycle
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", 16'(busy[0]), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 16'(busy[0]), 16'd0);
    chk("abort_done", 16'(done[0]), 16'd0);
    chk("abort_out", out[0], 16'h0000);
    chk("abort_cy", 16'(cy[0]), 16'd0);
    @(negedge clk);
    chk("abort_done2", 16'(done[0]), 16'd0);
    chk("abort_busy2", 16'(busy[0]), 16'd0);
    do_op(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 4, "after_rst");

    do_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1, "c16_add");
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, "c16_ovf");
    do_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16, "c1_ripple");
    do_op(2, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16, "c1_sub");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
